// File: rtl/mpt_pkg.sv
// mpt_pkg: shared MPT walker types, mode encodings and format-check definitions.
package mpt_pkg;
    localparam logic [3:0] MMPT_BARE    = 4'd0;
    localparam logic [3:0] MMPT_SMMPT43 = 4'd1;
    localparam logic [3:0] MMPT_SMMPT52 = 4'd2;
    localparam logic [3:0] MMPT_SMMPT64 = 4'd3;
    localparam int SMMPT43_W  = 43;
    localparam int SMMPT52_W  = 52;
    localparam int MODE_EN_43 = 0;
    localparam int MODE_EN_52 = 1;
    localparam int MODE_EN_64 = 2;
    typedef enum logic [1:0] {
        CF_NONE  = 2'd0,
        CF_BARE  = 2'd1,
        CF_MODE  = 2'd2,
        CF_RANGE = 2'd3
    } cf_cause_e;
    typedef struct packed {
        logic [3:0]  MODE;
        logic [43:0] ppn;
    } mmpt_t;
    typedef struct packed {
        mmpt_t       mmpt;
        logic [63:0] spa;
    } mptw_transaction_t;
    typedef struct packed {
        mptw_transaction_t trans;
        logic              fault;
        cf_cause_e         cause;
    } cf_entry_t;
    function automatic int min_w(int a, int b);
        return a < b ? a : b;
    endfunction
endpackage

// File: rtl/mpt_skid_buffer.sv
// mpt_skid_buffer: 2-entry valid/ready pipeline register (main + skid) for any payload type.
module mpt_skid_buffer #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  T     in_data,
    input  logic in_valid,
    output logic in_ready,
    output T     out_data,
    output logic out_valid,
    input  logic out_ready
);
    T     skid_data;
    logic skid_valid;
    logic accept;
    assign in_ready = ~skid_valid;
    assign accept   = in_valid & ~skid_valid & ~flush_i;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_data   <= '0;
            skid_data  <= '0;
        end else if (flush_i) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // main is free or draining: skid entry has priority over new input
            out_valid  <= skid_valid | accept;
            skid_valid <= 1'b0;
            if (skid_valid) out_data <= skid_data;
            else if (accept) out_data <= in_data;
        end else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end
endmodule

// File: rtl/mpt_check_format_pipe.sv
// mpt_check_format_pipe: SPA format check against MMPT mode and PLEN, skid-buffered output,
// saturating fault counter and sticky first-fault record.
module mpt_check_format_pipe
    import mpt_pkg::*;
#(
    parameter int         PLEN     = 64,
    parameter logic [2:0] MODES_EN = 3'b111,
    parameter int         CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  mptw_transaction_t in_transaction_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output mptw_transaction_t out_transaction_o,
    output logic              out_fault_o,
    output cf_cause_e         out_cause_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CNT_W-1:0]  fault_count_o,
    output logic              first_fault_valid_o,
    output logic [63:0]       first_fault_spa_o,
    output cf_cause_e         first_fault_cause_o,
    input  logic              clear_fault_i
);
    localparam int W43 = min_w(SMMPT43_W, PLEN);
    localparam int W52 = min_w(SMMPT52_W, PLEN);
    logic [63:0] spa;
    logic [3:0]  mode;
    cf_cause_e   cause;
    logic        fault;
    logic        accept;
    cf_entry_t   in_entry;
    cf_entry_t   out_entry;
    // shifting by 64 yields zero, so SMMPT64 with PLEN = 64 never range-faults
    always_comb begin
        spa      = in_transaction_i.spa;
        mode     = in_transaction_i.mmpt.MODE;
        cause    = mode == MMPT_BARE ? CF_BARE
                 : mode == MMPT_SMMPT43 && MODES_EN[MODE_EN_43] ? ((spa >> W43) != '0 ? CF_RANGE : CF_NONE)
                 : mode == MMPT_SMMPT52 && MODES_EN[MODE_EN_52] ? ((spa >> W52) != '0 ? CF_RANGE : CF_NONE)
                 : mode == MMPT_SMMPT64 && MODES_EN[MODE_EN_64] ? ((spa >> PLEN) != '0 ? CF_RANGE : CF_NONE)
                 : CF_MODE;
        fault    = cause != CF_NONE;
        accept   = in_valid_i & in_ready_o & ~flush_i;
        in_entry = '{trans: in_transaction_i, fault: fault, cause: cause};
    end
    mpt_skid_buffer #(.T(cf_entry_t)) u_skid (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .in_data   (in_entry),
        .in_valid  (in_valid_i),
        .in_ready  (in_ready_o),
        .out_data  (out_entry),
        .out_valid (out_valid_o),
        .out_ready (out_ready_i)
    );
    assign out_transaction_o = out_entry.trans;
    assign out_fault_o       = out_entry.fault;
    assign out_cause_o       = out_entry.cause;
    // an accepted fault beats a same-cycle clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fault_count_o       <= '0;
            first_fault_valid_o <= 1'b0;
            first_fault_spa_o   <= '0;
            first_fault_cause_o <= CF_NONE;
        end else if (accept && fault) begin
            fault_count_o       <= clear_fault_i ? CNT_W'(1) : fault_count_o + CNT_W'(~&fault_count_o);
            first_fault_valid_o <= 1'b1;
            if (clear_fault_i || !first_fault_valid_o) begin
                first_fault_spa_o   <= spa;
                first_fault_cause_o <= cause;
            end
        end else if (clear_fault_i) begin
            fault_count_o       <= '0;
            first_fault_valid_o <= 1'b0;
            first_fault_spa_o   <= '0;
            first_fault_cause_o <= CF_NONE;
        end
    end
endmodule

// File: tb/tb_mpt_check_format_pipe.sv
// tb_mpt_check_format_pipe: three parameter variants driven in lockstep, checked against
// directed constants and a queue-based reference model.
module tb_mpt_check_format_pipe;
    import mpt_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1, clear = 1'b0;
    mptw_transaction_t in_t = '0;
    logic [2:0] o_valid, o_fault, i_ready, ffv;
    mptw_transaction_t o_t [3];
    cf_cause_e o_c [3];
    cf_cause_e ff_c [3];
    logic [63:0] ff_spa [3];
    logic [15:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic [15:0] cnt [3];
    int errors = 0, checks = 0;
    always #5 clk = ~clk;
    assign cnt[0] = cnt0;
    assign cnt[1] = cnt1;
    assign cnt[2] = {14'd0, cnt2};

    mpt_check_format_pipe u0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_transaction_i(in_t), .in_valid_i(in_valid),
        .in_ready_o(i_ready[0]), .out_transaction_o(o_t[0]), .out_fault_o(o_fault[0]), .out_cause_o(o_c[0]),
        .out_valid_o(o_valid[0]), .out_ready_i(out_ready), .fault_count_o(cnt0), .first_fault_valid_o(ffv[0]),
        .first_fault_spa_o(ff_spa[0]), .first_fault_cause_o(ff_c[0]), .clear_fault_i(clear));
    mpt_check_format_pipe #(.PLEN(56)) u1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_transaction_i(in_t), .in_valid_i(in_valid),
        .in_ready_o(i_ready[1]), .out_transaction_o(o_t[1]), .out_fault_o(o_fault[1]), .out_cause_o(o_c[1]),
        .out_valid_o(o_valid[1]), .out_ready_i(out_ready), .fault_count_o(cnt1), .first_fault_valid_o(ffv[1]),
        .first_fault_spa_o(ff_spa[1]), .first_fault_cause_o(ff_c[1]), .clear_fault_i(clear));
    mpt_check_format_pipe #(.PLEN(48), .MODES_EN(3'b011), .CNT_W(2)) u2 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_transaction_i(in_t), .in_valid_i(in_valid),
        .in_ready_o(i_ready[2]), .out_transaction_o(o_t[2]), .out_fault_o(o_fault[2]), .out_cause_o(o_c[2]),
        .out_valid_o(o_valid[2]), .out_ready_i(out_ready), .fault_count_o(cnt2), .first_fault_valid_o(ffv[2]),
        .first_fault_spa_o(ff_spa[2]), .first_fault_cause_o(ff_c[2]), .clear_fault_i(clear));

    // reference model: per-variant configuration, buffered items in order, counters and records
    int pl [3] = '{64, 56, 48};
    logic [2:0] men [3] = '{3'b111, 3'b111, 3'b011};
    int cmax [3] = '{65535, 65535, 3};
    typedef struct packed {
        mptw_transaction_t t;
        logic [2:0][1:0] c;
    } item_t;
    item_t q [$];
    int m_cnt [3];
    logic m_ffv [3];
    logic [63:0] m_spa [3];
    logic [1:0] m_fc [3];

    function automatic logic [1:0] ref_cause(mptw_transaction_t t, int k);
        int lim;
        if (t.mmpt.MODE == 4'd0) return 2'd1;
        if (t.mmpt.MODE == 4'd1 && men[k][0]) lim = 43;
        else if (t.mmpt.MODE == 4'd2 && men[k][1]) lim = 52;
        else if (t.mmpt.MODE == 4'd3 && men[k][2]) lim = 64;
        else return 2'd2;
        if (pl[k] < lim) lim = pl[k];
        return (lim < 64 && (t.spa >> lim) != 64'd0) ? 2'd3 : 2'd0;
    endfunction

    function automatic logic [63:0] rand_spa();
        logic [63:0] s;
        s = {$urandom, $urandom};
        return s >> $urandom_range(0, 30);
    endfunction

    task automatic drive(logic v, logic [3:0] m, logic [63:0] s);
        in_valid = v;
        in_t = '0;
        in_t.mmpt.MODE = m;
        in_t.mmpt.ppn = 44'({$urandom, $urandom});
        in_t.spa = s;
    endtask

    task automatic tick();
        logic acc, pop;
        item_t it;
        acc = in_valid && q.size() < 2 && !flush;
        pop = out_ready && q.size() > 0;
        it.t = in_t;
        for (int k = 0; k < 3; k++) it.c[k] = ref_cause(in_t, k);
        @(posedge clk);
        if (rst) begin
            q.delete();
            for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_ffv[k] = 0; m_spa[k] = '0; m_fc[k] = '0; end
        end else begin
            if (flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(it);
            end
            for (int k = 0; k < 3; k++) begin
                if (clear) begin m_cnt[k] = 0; m_ffv[k] = 0; m_spa[k] = '0; m_fc[k] = '0; end
                if (acc && it.c[k] != 2'd0) begin
                    if (m_cnt[k] < cmax[k]) m_cnt[k]++;
                    if (!m_ffv[k]) begin m_ffv[k] = 1; m_spa[k] = it.t.spa; m_fc[k] = it.c[k]; end
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; drive(1, 4'd1, rand_spa());
        tick();
        rst = 0; in_valid = 0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (o_valid[k] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d] got=%0b exp=0", k, o_valid[k]); end
            checks++; if (o_fault[k] !== 1'b0) begin errors++; $display("FAIL reset_fault[%0d] got=%0b exp=0", k, o_fault[k]); end
            checks++; if (o_c[k] !== CF_NONE) begin errors++; $display("FAIL reset_cause[%0d] got=%0d exp=0", k, o_c[k]); end
            checks++; if (o_t[k] !== '0) begin errors++; $display("FAIL reset_trans[%0d] got=%0h exp=0", k, o_t[k]); end
            checks++; if (i_ready[k] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d] got=%0b exp=1", k, i_ready[k]); end
            checks++; if (cnt[k] !== 16'd0) begin errors++; $display("FAIL reset_count[%0d] got=%0d exp=0", k, cnt[k]); end
            checks++; if (ffv[k] !== 1'b0) begin errors++; $display("FAIL reset_ffv[%0d] got=%0b exp=0", k, ffv[k]); end
            checks++; if (ff_spa[k] !== 64'd0) begin errors++; $display("FAIL reset_ffspa[%0d] got=%0h exp=0", k, ff_spa[k]); end
            checks++; if (ff_c[k] !== CF_NONE) begin errors++; $display("FAIL reset_ffcause[%0d] got=%0d exp=0", k, ff_c[k]); end
        end
    endtask

    logic [3:0] tm [6] = '{4'd1, 4'd1, 4'd3, 4'd0, 4'd5, 4'd2};
    logic [63:0] ts [6] = '{64'h0000_07FF_FFFF_F000, 64'h0000_0800_0000_0000, 64'h0100_0000_0000_0000,
                            64'hFFFF_0000_0000_0000, 64'h0, 64'h0004_0000_0000_0000};
    logic [1:0] te [6][3] = '{'{2'd0, 2'd0, 2'd0}, '{2'd3, 2'd3, 2'd3}, '{2'd0, 2'd3, 2'd2},
                              '{2'd1, 2'd1, 2'd1}, '{2'd2, 2'd2, 2'd2}, '{2'd0, 2'd0, 2'd3}};
    int ecnt0 [6] = '{0, 1, 1, 2, 3, 3};

    task automatic test_modes();
        mptw_transaction_t sent;
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            drive(1, tm[i], ts[i]);
            sent = in_t;
            tick();
            in_valid = 0;
            for (int k = 0; k < 3; k++) begin
                checks++; if (o_valid[k] !== 1'b1) begin errors++; $display("FAIL mode%0d_valid[%0d] got=%0b exp=1", i, k, o_valid[k]); end
                checks++; if (o_c[k] !== te[i][k]) begin errors++; $display("FAIL mode%0d_cause[%0d] got=%0d exp=%0d", i, k, o_c[k], te[i][k]); end
                checks++; if (o_fault[k] !== (te[i][k] != 2'd0)) begin errors++; $display("FAIL mode%0d_fault[%0d] got=%0b exp=%0b", i, k, o_fault[k], te[i][k] != 2'd0); end
                checks++; if (o_t[k] !== sent) begin errors++; $display("FAIL mode%0d_trans[%0d] got=%0h exp=%0h", i, k, o_t[k], sent); end
            end
            checks++; if (cnt[0] !== 16'(ecnt0[i])) begin errors++; $display("FAIL mode%0d_count got=%0d exp=%0d", i, cnt[0], ecnt0[i]); end
            if (i >= 1) begin
                checks++; if (ff_spa[0] !== ts[1]) begin errors++; $display("FAIL mode%0d_ffspa got=%0h exp=%0h", i, ff_spa[0], ts[1]); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        mptw_transaction_t sent [$];
        mptw_transaction_t got [$];
        int low = 0;
        for (int cyc = 0; cyc < 30 && got.size() < 4; cyc++) begin
            out_ready = (cyc != 1);
            if (sent.size() < 4) drive(1, 4'($urandom_range(0, 3)), rand_spa());
            else in_valid = 0;
            if (!i_ready[0]) low++;
            if (in_valid && i_ready[0]) sent.push_back(in_t);
            if (o_valid[0] && out_ready) got.push_back(o_t[0]);
            tick();
        end
        in_valid = 0; out_ready = 1;
        checks++; if (low != 1) begin errors++; $display("FAIL b2b_ready_low got=%0d exp=1", low); end
        checks++; if (sent.size() != 4) begin errors++; $display("FAIL b2b_sent got=%0d exp=4", sent.size()); end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL b2b_delivered got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4 && i < got.size() && i < sent.size(); i++) begin
            checks++; if (got[i] !== sent[i]) begin errors++; $display("FAIL b2b_order%0d got=%0h exp=%0h", i, got[i], sent[i]); end
        end
    endtask

    task automatic test_clear_saturate();
        logic [63:0] spa4 = 64'hDEAD_BEEF_0000_1234;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin drive(1, 4'd0, rand_spa()); tick(); end
        drive(1, 4'd0, spa4); clear = 1;
        tick();
        clear = 0; in_valid = 0;
        checks++; if (cnt[0] !== 16'd1) begin errors++; $display("FAIL clr_count0 got=%0d exp=1", cnt[0]); end
        checks++; if (cnt[2] !== 16'd1) begin errors++; $display("FAIL clr_count2 got=%0d exp=1", cnt[2]); end
        checks++; if (ffv[0] !== 1'b1) begin errors++; $display("FAIL clr_ffv got=%0b exp=1", ffv[0]); end
        checks++; if (ff_spa[0] !== spa4) begin errors++; $display("FAIL clr_ffspa got=%0h exp=%0h", ff_spa[0], spa4); end
        checks++; if (ff_c[0] !== CF_BARE) begin errors++; $display("FAIL clr_ffcause got=%0d exp=1", ff_c[0]); end
        for (int i = 0; i < 4; i++) begin drive(1, 4'd0, rand_spa()); tick(); end
        in_valid = 0;
        tick();
        checks++; if (cnt[0] !== 16'd5) begin errors++; $display("FAIL sat_count0 got=%0d exp=5", cnt[0]); end
        checks++; if (cnt[2] !== 16'd3) begin errors++; $display("FAIL sat_count2 got=%0d exp=3", cnt[2]); end
        checks++; if (ff_spa[2] !== spa4) begin errors++; $display("FAIL sat_ffspa2 got=%0h exp=%0h", ff_spa[2], spa4); end
        clear = 1;
        tick();
        clear = 0;
        checks++; if (cnt[0] !== 16'd0) begin errors++; $display("FAIL clear_count got=%0d exp=0", cnt[0]); end
        checks++; if (ffv[0] !== 1'b0) begin errors++; $display("FAIL clear_ffv got=%0b exp=0", ffv[0]); end
        checks++; if (ff_spa[0] !== 64'd0) begin errors++; $display("FAIL clear_ffspa got=%0h exp=0", ff_spa[0]); end
    endtask

    task automatic test_flush();
        out_ready = 0;
        drive(1, 4'd0, 64'h1111); tick();
        drive(1, 4'd1, 64'h0); tick();
        checks++; if (i_ready[0] !== 1'b0) begin errors++; $display("FAIL flush_full_ready got=%0b exp=0", i_ready[0]); end
        flush = 1; drive(1, 4'd0, 64'h2222);
        tick();
        flush = 0; in_valid = 0;
        checks++; if (o_valid[0] !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", o_valid[0]); end
        checks++; if (i_ready[0] !== 1'b1) begin errors++; $display("FAIL flush_ready got=%0b exp=1", i_ready[0]); end
        checks++; if (cnt[0] !== 16'd1) begin errors++; $display("FAIL flush_count got=%0d exp=1", cnt[0]); end
        checks++; if (ff_spa[0] !== 64'h1111) begin errors++; $display("FAIL flush_ffspa got=%0h exp=1111", ff_spa[0]); end
        drive(1, 4'd1, 64'h0); tick();
        flush = 1; drive(1, 4'd0, 64'h3333);
        tick();
        flush = 0; in_valid = 0;
        checks++; if (o_valid[0] !== 1'b0) begin errors++; $display("FAIL flush2_valid got=%0b exp=0", o_valid[0]); end
        checks++; if (cnt[0] !== 16'd1) begin errors++; $display("FAIL flush2_count got=%0d exp=1", cnt[0]); end
        out_ready = 1;
    endtask

    task automatic test_reset_mid();
        out_ready = 0;
        drive(1, 4'd0, rand_spa()); tick();
        drive(1, 4'd2, rand_spa()); tick();
        checks++; if (i_ready[0] !== 1'b0) begin errors++; $display("FAIL mid_skid_full got=%0b exp=0", i_ready[0]); end
        test_reset();
        out_ready = 1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 99) < 3);
            clear = ($urandom_range(0, 99) < 4);
            out_ready = ($urandom_range(0, 99) < 60);
            drive($urandom_range(0, 99) < 70, 4'($urandom_range(0, 5)), rand_spa());
            tick();
            for (int k = 0; k < 3; k++) begin
                checks++; if (o_valid[k] !== (q.size() > 0)) begin errors++; $display("FAIL rnd%0d_valid[%0d] got=%0b exp=%0b", n, k, o_valid[k], q.size() > 0); end
                checks++; if (i_ready[k] !== (q.size() < 2)) begin errors++; $display("FAIL rnd%0d_ready[%0d] got=%0b exp=%0b", n, k, i_ready[k], q.size() < 2); end
                if (q.size() > 0) begin
                    checks++; if (o_t[k] !== q[0].t) begin errors++; $display("FAIL rnd%0d_trans[%0d] got=%0h exp=%0h", n, k, o_t[k], q[0].t); end
                    checks++; if (o_c[k] !== q[0].c[k]) begin errors++; $display("FAIL rnd%0d_cause[%0d] got=%0d exp=%0d", n, k, o_c[k], q[0].c[k]); end
                    checks++; if (o_fault[k] !== (q[0].c[k] != 2'd0)) begin errors++; $display("FAIL rnd%0d_fault[%0d] got=%0b", n, k, o_fault[k]); end
                end
                checks++; if (cnt[k] !== 16'(m_cnt[k])) begin errors++; $display("FAIL rnd%0d_count[%0d] got=%0d exp=%0d", n, k, cnt[k], m_cnt[k]); end
                checks++; if (ffv[k] !== m_ffv[k]) begin errors++; $display("FAIL rnd%0d_ffv[%0d] got=%0b exp=%0b", n, k, ffv[k], m_ffv[k]); end
                checks++; if (ff_spa[k] !== m_spa[k]) begin errors++; $display("FAIL rnd%0d_ffspa[%0d] got=%0h exp=%0h", n, k, ff_spa[k], m_spa[k]); end
                checks++; if (ff_c[k] !== m_fc[k]) begin errors++; $display("FAIL rnd%0d_ffcause[%0d] got=%0d exp=%0d", n, k, ff_c[k], m_fc[k]); end
            end
        end
        rst = 0; flush = 0; clear = 0; in_valid = 0; out_ready = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_modes();
        test_back_to_back();
        test_clear_saturate();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
